// File: rtl/linebuf_pkg.sv
// ---------------------------------------------------------------------------
// linebuf_pkg
// Shared width helpers for the line window buffer.
//   hcount_width(max_len)   : bits for the horizontal pixel counter, which
//                             never exceeds max_len-1
//   bank_width(num_lines)   : bits for the write-bank pointer that walks
//                             0..num_lines-2
//   fill_width(num_lines)   : bits for the fill counter, which saturates
//                             at num_lines-1
// Every helper returns at least 1 so that degenerate sizes still give
// legal vector widths.
// ---------------------------------------------------------------------------
package linebuf_pkg;

    function automatic int hcount_width(input int max_len);
        return (max_len > 2) ? $clog2(max_len) : 1;
    endfunction

    function automatic int bank_width(input int num_lines);
        return (num_lines > 2) ? $clog2(num_lines - 1) : 1;
    endfunction

    function automatic int fill_width(input int num_lines);
        return (num_lines > 2) ? $clog2(num_lines) : 1;
    endfunction

endpackage

// File: rtl/linebuf_ram.sv
// ---------------------------------------------------------------------------
// linebuf_ram
// Storage for one video line. A single address drives both the write and
// the read. The read is combinational from the array, so within a cycle it
// returns the contents from before this cycle's write (read-before-write).
// Ports:
//   clk   : clock, write happens on the rising edge
//   we    : write enable
//   addr  : shared read/write address (pixel column)
//   wdata : pixel to store
//   rdata : pixel previously stored at addr
// ---------------------------------------------------------------------------
module linebuf_ram
    import linebuf_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/line_window_buffer.sv
// ---------------------------------------------------------------------------
// line_window_buffer
// Builds a vertical window of NUM_LINES pixels, one column per input pixel.
// The NUM_LINES-1 previous lines are kept in a ring of linebuf_ram banks.
// The current pixel is always the newest slice of the column.
//
// Parameters:
//   DATA_WIDTH      : pixel width
//   MAX_DATA_LENGTH : longest line that is stored; any extra pixels are
//                     dropped and flagged
//   NUM_LINES       : window height, legal range 2..8
// Ports:
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   vsync_i    : frame start; clears line state and wins over de_i
//   de_i       : pixel enable, one pixel per cycle while high
//   data_i     : incoming pixel
//   de_o       : column valid, one cycle after the accepted pixel
//   data_o     : column; slice 0 = oldest line, slice NUM_LINES-1 = current
//   overflow_o : sticky within a frame; a line was longer than
//                MAX_DATA_LENGTH
//
// Stream semantics: de_i/de_o are valid-only strobes with no ready and no
// backpressure. Every cycle with de_i high (and vsync_i low) consumes
// exactly one pixel. de_o marks each cycle in which data_o holds a new
// column. data_o keeps its last value while de_o is low.
//
// Optional feature, macro LINEBUF_EDGE_REPLICATE_EN: while the ring is
// still filling at the top of a frame, missing older lines are replaced by
// the oldest line that is present, and de_o follows de_i from line 1.
// ---------------------------------------------------------------------------
module line_window_buffer
    import linebuf_pkg::*;
#(
    parameter int DATA_WIDTH      = 10,
    parameter int MAX_DATA_LENGTH = 1024,
    parameter int NUM_LINES       = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            vsync_i,
    input  logic                            de_i,
    input  logic [DATA_WIDTH-1:0]           data_i,
    output logic                            de_o,
    output logic [NUM_LINES*DATA_WIDTH-1:0] data_o,
    output logic                            overflow_o
);

    localparam int HCW = hcount_width(MAX_DATA_LENGTH);
    localparam int BW  = bank_width(NUM_LINES);
    localparam int FW  = fill_width(NUM_LINES);
    localparam int NB  = NUM_LINES - 1;

    localparam logic [HCW-1:0] HC_LAST   = HCW'(MAX_DATA_LENGTH - 1);
    localparam logic [BW-1:0]  BANK_LAST = BW'(NB - 1);
    localparam logic [FW-1:0]  FILL_FULL = FW'(NB);

    logic [HCW-1:0] hcount;
    logic [BW-1:0]  wbank;
    logic [FW-1:0]  fill;
    logic           de_d;       // accepted-pixel strobe from last cycle
    logic           line_full;  // pixel MAX_DATA_LENGTH-1 already stored
    logic           drop_line;  // rest of an interrupted line is ignored

    logic accept;
    logic wr_en;
    logic line_end;
    logic out_valid;

    logic [DATA_WIDTH-1:0]           rd_data [NB];
    logic [DATA_WIDTH-1:0]           col     [NUM_LINES];
    logic [DATA_WIDTH-1:0]           col_out [NUM_LINES];
    logic [NUM_LINES*DATA_WIDTH-1:0] col_packed;

    // A line cut short by rst or vsync_i is discarded up to its de_i fall.
    // That keeps the bank ring aligned with whole lines.
    assign accept   = de_i & ~vsync_i & ~drop_line;
    assign wr_en    = accept & ~line_full & ~rst;
    assign line_end = de_d & ~accept;

`ifdef LINEBUF_EDGE_REPLICATE_EN
    assign out_valid = accept;
`else
    assign out_valid = accept & (fill == FILL_FULL);
`endif

    // Line memories, one per stored line
    for (genvar b = 0; b < NB; b++) begin : g_bank
        linebuf_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (MAX_DATA_LENGTH),
            .ADDR_WIDTH (HCW)
        ) u_ram (
            .clk   (clk),
            .we    (wr_en && (wbank == BW'(b))),
            .addr  (hcount),
            .wdata (data_i),
            .rdata (rd_data[b])
        );
    end

    // Rotate the banks so slice 0 is the oldest line. The bank about to be
    // written (wbank) holds the oldest data, since the read is before the
    // write.
    always_comb begin
        for (int k = 0; k < NUM_LINES; k++) begin
            col[k] = '0;
        end
        for (int k = 0; k < NB; k++) begin
            for (int b = 0; b < NB; b++) begin
                if (((int'(wbank) + k) % NB) == b) begin
                    col[k] = rd_data[b];
                end
            end
        end
        col[NUM_LINES-1] = data_i;
    end

`ifdef LINEBUF_EDGE_REPLICATE_EN
    // Slices older than the fill level copy the oldest valid slice. That
    // slice is NUM_LINES-1-fill, so at fill 0 every slice is the current
    // pixel.
    always_comb begin
        for (int k = 0; k < NUM_LINES; k++) begin
            col_out[k] = col[k];
        end
        for (int k = 0; k < NB; k++) begin
            if (k < (NB - int'(fill))) begin
                for (int j = 0; j < NUM_LINES; j++) begin
                    if (j == (NB - int'(fill))) begin
                        col_out[k] = col[j];
                    end
                end
            end
        end
    end
`else
    always_comb begin
        for (int k = 0; k < NUM_LINES; k++) begin
            col_out[k] = col[k];
        end
    end
`endif

    always_comb begin
        col_packed = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            col_packed[k*DATA_WIDTH +: DATA_WIDTH] = col_out[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount     <= '0;
            wbank      <= '0;
            fill       <= '0;
            de_d       <= 1'b0;
            line_full  <= 1'b0;
            drop_line  <= de_i;
            de_o       <= 1'b0;
            data_o     <= '0;
            overflow_o <= 1'b0;
        end else if (vsync_i) begin
            hcount     <= '0;
            wbank      <= '0;
            fill       <= '0;
            de_d       <= 1'b0;
            line_full  <= 1'b0;
            drop_line  <= de_i;
            de_o       <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            de_d <= accept;

            if (!de_i) begin
                drop_line <= 1'b0;
            end

            if (accept) begin
                if (!line_full) begin
                    // Park on the last column. Later pixels of this line
                    // read it but never overwrite it.
                    if (hcount == HC_LAST) begin
                        line_full <= 1'b1;
                    end else begin
                        hcount <= hcount + 1'b1;
                    end
                end else begin
                    overflow_o <= 1'b1;
                end
            end else begin
                hcount    <= '0;
                line_full <= 1'b0;
            end

            if (line_end) begin
                wbank <= (wbank == BANK_LAST) ? '0 : wbank + 1'b1;
                if (fill != FILL_FULL) begin
                    fill <= fill + 1'b1;
                end
            end

            de_o <= out_valid;
            if (out_valid) begin
                data_o <= col_packed;
            end
        end
    end

endmodule

// File: tb/tb_line_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_line_window_buffer
// Directed bench for line_window_buffer. Two instances share all inputs:
//   dut3 : DATA_WIDTH=8, MAX_DATA_LENGTH=480, NUM_LINES=3
//   dut5 : DATA_WIDTH=8, MAX_DATA_LENGTH=480, NUM_LINES=5
// Pixel values are truncated to 8 bits, so 480 appears as 224, and so on.
// Expected columns are built from the line base values.
// ---------------------------------------------------------------------------
module tb_line_window_buffer;

    localparam int DW   = 8;
    localparam int MAXL = 480;

`ifdef LINEBUF_EDGE_REPLICATE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic rst;
    logic vsync;
    logic de;
    logic [DW-1:0] din;

    logic          de3, ovf3, de5, ovf5;
    logic [3*DW-1:0] dout3;
    logic [5*DW-1:0] dout5;

    always #5 clk = ~clk;

    line_window_buffer #(.DATA_WIDTH(DW), .MAX_DATA_LENGTH(MAXL), .NUM_LINES(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .vsync_i    (vsync),
        .de_i       (de),
        .data_i     (din),
        .de_o       (de3),
        .data_o     (dout3),
        .overflow_o (ovf3)
    );

    line_window_buffer #(.DATA_WIDTH(DW), .MAX_DATA_LENGTH(MAXL), .NUM_LINES(5)) dut5 (
        .clk        (clk),
        .rst        (rst),
        .vsync_i    (vsync),
        .de_i       (de),
        .data_i     (din),
        .de_o       (de5),
        .data_o     (dout5),
        .overflow_o (ovf5)
    );

    // ---------------- scoreboard / checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-pixel capture of the last line that was sent
    logic [3*DW-1:0] cap_col3 [512];
    logic [5*DW-1:0] cap_col5 [512];
    logic            cap_de3  [512];
    logic            cap_de5  [512];
    logic            cap_ovf3 [512];

    function automatic logic [3*DW-1:0] col3(input int s0, input int s1, input int s2);
        logic [DW-1:0] a, b, c;
        a = DW'(s0);
        b = DW'(s1);
        c = DW'(s2);
        return {c, b, a};
    endfunction

    function automatic logic [5*DW-1:0] col5(input int s0, input int s1, input int s2,
                                             input int s3, input int s4);
        logic [DW-1:0] a, b, c, d, e;
        a = DW'(s0);
        b = DW'(s1);
        c = DW'(s2);
        d = DW'(s3);
        e = DW'(s4);
        return {e, d, c, b, a};
    endfunction

    function automatic int de3_count(input int len);
        int c = 0;
        for (int x = 0; x < len; x++) c += int'(cap_de3[x]);
        return c;
    endfunction

    function automatic int de5_count(input int len);
        int c = 0;
        for (int x = 0; x < len; x++) c += int'(cap_de5[x]);
        return c;
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge. Outputs are sampled
    // 1 time unit after the edge that took the pixel in.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        step();
    endtask

    task automatic send_line(input int base, input int len, input int rst_at);
        for (int x = 0; x < len; x++) begin
            de  = 1'b1;
            din = DW'(base + x);
            rst = (x == rst_at);
            step();
            cap_de3[x]  = de3;
            cap_col3[x] = dout3;
            cap_ovf3[x] = ovf3;
            cap_de5[x]  = de5;
            cap_col5[x] = dout5;
        end
        de  = 1'b0;
        rst = 1'b0;
        din = '0;
        repeat (4) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b1;
        vsync = 1'b0;
        de    = 1'b0;
        din   = '0;
        repeat (3) step();
        check("reset_de_o",       64'(de3),   64'(0));
        check("reset_data_o",     64'(dout3), 64'(0));
        check("reset_overflow",   64'(ovf3),  64'(0));
        check("reset5_data_o",    64'(dout5), 64'(0));
        check("reset5_overflow",  64'(ovf5),  64'(0));
        rst = 1'b0;
        step();

        // Three full lines: window only on line 3
        frame_start();
        send_line(0, 480, -1);
        check("fill_l1_de_count", 64'(de3_count(480)), 64'(REPL ? 480 : 0));
        send_line(480, 480, -1);
        check("fill_l2_de_count", 64'(de3_count(480)), 64'(REPL ? 480 : 0));
        send_line(960, 480, -1);
        check("fill_l3_de_count", 64'(de3_count(480)), 64'(480));
        check("fill_l3_first",    64'(cap_col3[0]),   64'(col3(0, 480, 960)));
        check("fill_l3_mid",      64'(cap_col3[240]), 64'(col3(240, 720, 1200)));
        check("fill_l3_last",     64'(cap_col3[479]), 64'(col3(479, 959, 1439)));
        check("idle_de_low",      64'(de3),   64'(0));
        check("idle_data_hold",   64'(dout3), 64'(col3(479, 959, 1439)));

        // Five-line window, six short lines, value n*16+x
        frame_start();
        for (int n = 0; n < 6; n++) begin
            send_line(n * 16, 16, -1);
            if (n == 2) check("nl3_l3_first", 64'(cap_col3[0]), 64'(col3(0, 16, 32)));
            if (n == 3) check("nl5_l4_de_count", 64'(de5_count(16)), 64'(REPL ? 16 : 0));
            if (n == 4) begin
                check("nl5_l5_de",    64'(cap_de5[0]),  64'(1));
                check("nl5_l5_first", 64'(cap_col5[0]), 64'(col5(0, 16, 32, 48, 64)));
                check("nl5_l5_last",  64'(cap_col5[15]), 64'(col5(15, 31, 47, 63, 79)));
            end
            if (n == 5) check("nl5_l6_first", 64'(cap_col5[0]), 64'(col5(16, 32, 48, 64, 80)));
        end

        // Overlong line: drop past column 479, sticky flag
        frame_start();
        send_line(0, 485, -1);
        check("ovf_at_479",       64'(cap_ovf3[479]), 64'(0));
        check("ovf_at_480",       64'(cap_ovf3[480]), 64'(1));
        check("ovf_held_idle",    64'(ovf3), 64'(1));
        check("ovf_l1_de_count",  64'(de3_count(485)), 64'(REPL ? 485 : 0));
        send_line(1000, 480, -1);
        send_line(2000, 480, -1);
        check("ovf_keeps_479",    64'(cap_col3[479]), 64'(col3(479, 1479, 2479)));
        check("ovf_sticky",       64'(ovf3), 64'(1));
        vsync = 1'b1;
        step();
        check("ovf_vsync_clear",  64'(ovf3), 64'(0));
        vsync = 1'b0;
        step();

        // vsync coincident with the first pixel
        vsync = 1'b1;
        de    = 1'b1;
        din   = 8'd99;
        step();
        check("vs_pixel_no_de",   64'(de3), 64'(0));
        vsync = 1'b0;
        de    = 1'b0;
        din   = '0;
        repeat (2) step();
        send_line(300, 8, -1);
        check("vs_l1_de_count",   64'(de3_count(8)), 64'(REPL ? 8 : 0));
        send_line(400, 8, -1);
        check("vs_l2_de_count",   64'(de3_count(8)), 64'(REPL ? 8 : 0));
        send_line(500, 8, -1);
        check("vs_l3_de",         64'(cap_de3[0]),  64'(1));
        check("vs_l3_first",      64'(cap_col3[0]), 64'(col3(300, 400, 500)));

        // Reset in the middle of line 3
        frame_start();
        send_line(0, 485, -1);
        check("rst_pre_overflow", 64'(ovf3), 64'(1));
        send_line(600, 300, -1);
        send_line(900, 300, 200);
        check("rst_pre_de",       64'(cap_de3[199]), 64'(1));
        check("rst_de_cleared",   64'(cap_de3[200]), 64'(0));
        check("rst_data_cleared", 64'(cap_col3[200]), 64'(0));
        check("rst_ovf_cleared",  64'(cap_ovf3[200]), 64'(0));
        check("rst_line_dropped", 64'(de3_count(300)), 64'(200));
        send_line(1200, 300, -1);
        check("rst_l1_de_count",  64'(de3_count(300)), 64'(REPL ? 300 : 0));
        send_line(1500, 300, -1);
        check("rst_l2_de_count",  64'(de3_count(300)), 64'(REPL ? 300 : 0));
        send_line(1800, 300, -1);
        check("rst_l3_de_count",  64'(de3_count(300)), 64'(300));
        check("rst_l3_first",     64'(cap_col3[0]), 64'(col3(1200, 1500, 1800)));

        // Top-of-frame behaviour at pixel 7
        frame_start();
        send_line(0, 16, -1);
`ifdef LINEBUF_EDGE_REPLICATE_EN
        check("rep_l1_de",        64'(cap_de3[7]),  64'(1));
        check("rep_l1_col",       64'(cap_col3[7]), 64'(col3(7, 7, 7)));
        send_line(480, 16, -1);
        check("rep_l2_de",        64'(cap_de3[7]),  64'(1));
        check("rep_l2_col",       64'(cap_col3[7]), 64'(col3(7, 7, 487)));
`else
        check("norep_l1_de",      64'(cap_de3[7]), 64'(0));
        send_line(480, 16, -1);
        check("norep_l2_de",      64'(cap_de3[7]), 64'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net against a stuck run
    initial begin
        #1000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
